// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - single-port framebuffer RAM arbiter: display reads vs buffered PPU writes
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   rd_req/rd_addr/rd_gnt       display read request, address, same-cycle grant
//   rd_valid/rd_data            read data, two cycles after grant
//   wr_valid/wr_addr/wr_data    PPU write push, accepted when wr_ready
//   wr_ready, wfifo_level       write FIFO not full, FIFO occupancy
//   fifo_flush                  discard all pending writes
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   registered RAM drive, 1-cycle read data
//
// Optional feature: FB_ARB_STARVE_GUARD_EN forces a write slot after STARVE_MAX starved cycles.

module fb_arbiter #(
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 16,
  parameter int WFIFO_DEPTH = 4,
  parameter int STARVE_MAX  = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           rd_req,
  input  logic [ADDR_W-1:0]              rd_addr,
  output logic                           rd_gnt,
  output logic                           rd_valid,
  output logic [DATA_W-1:0]              rd_data,
  input  logic                           wr_valid,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [DATA_W-1:0]              wr_data,
  output logic                           wr_ready,
  input  logic                           fifo_flush,
  output logic [$clog2(WFIFO_DEPTH):0]   wfifo_level,
  output logic                           mem_en,
  output logic                           mem_we,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W-1:0]              mem_rdata
);

  localparam int PTR_W = $clog2(WFIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_READ  = 2'd1,
    SLOT_WRITE = 2'd2
  } slot_t;

  // Write FIFO storage and bookkeeping
  logic [ADDR_W-1:0] fifo_addr [WFIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [WFIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;

  logic  fifo_empty;
  logic  fifo_full;
  logic  push;
  logic  pop;
  logic  force_write;
  slot_t slot;
  logic  rd_pend;

  assign fifo_empty  = (level == '0);
  assign fifo_full   = (level == LVL_W'(WFIFO_DEPTH));
  // Readiness comes from the registered level, so a pop in a full cycle
  // only frees space for the following cycle.
  assign wr_ready    = !fifo_full && !fifo_flush;
  assign push        = wr_valid && wr_ready;
  assign wfifo_level = level;

`ifdef FB_ARB_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_MAX + 1);

  logic [SC_W-1:0] starve_cnt;

  // Once the write queue has waited STARVE_MAX cycles, steal one slot from reads.
  assign force_write = (starve_cnt == SC_W'(STARVE_MAX)) && !fifo_empty && !fifo_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (slot == SLOT_WRITE || fifo_flush || fifo_empty) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SC_W'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + SC_W'(1);
    end
  end
`else
  // Guard absent: reads always win (expression is constant false).
  assign force_write = (STARVE_MAX < 0);
`endif

  // Slot arbitration: reads first, then FIFO drain; never drain during a flush.
  always_comb begin
    slot = SLOT_IDLE;
    if (rd_req && !force_write) begin
      slot = SLOT_READ;
    end else if (!fifo_empty && !fifo_flush) begin
      slot = SLOT_WRITE;
    end
  end

  assign rd_gnt = (slot == SLOT_READ);
  assign pop    = (slot == SLOT_WRITE);

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (fifo_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // FIFO payload needs no reset; validity is tracked by level.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  // Registered RAM drive; address and data hold through idle slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= (slot != SLOT_IDLE);
      mem_we <= (slot == SLOT_WRITE);
      case (slot)
        SLOT_READ: begin
          mem_addr <= rd_addr;
        end
        SLOT_WRITE: begin
          mem_addr  <= fifo_addr[rd_ptr];
          mem_wdata <= fifo_data[rd_ptr];
        end
        default: begin
          mem_addr  <= mem_addr;
          mem_wdata <= mem_wdata;
        end
      endcase
    end
  end

  // Read valid pipeline: grant -> RAM drive -> RAM data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend  <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_pend  <= rd_gnt;
      rd_valid <= rd_pend;
    end
  end

  assign rd_data = rd_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_fb_arbiter.sv
// tb/tb_fb_arbiter.sv - randomized self-checking bench for fb_arbiter against a queue-based model

module tb_fb_arbiter;

  localparam int AW    = 15;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int SMAX  = 8;
`ifdef FB_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic                      clk;
  logic                      rst_n;
  logic                      rd_req;
  logic [AW-1:0]             rd_addr;
  logic                      rd_gnt;
  logic                      rd_valid;
  logic [DW-1:0]             rd_data;
  logic                      wr_valid;
  logic [AW-1:0]             wr_addr;
  logic [DW-1:0]             wr_data;
  logic                      wr_ready;
  logic                      fifo_flush;
  logic [$clog2(DEPTH):0]    wfifo_level;
  logic                      mem_en;
  logic                      mem_we;
  logic [AW-1:0]             mem_addr;
  logic [DW-1:0]             mem_wdata;
  logic [DW-1:0]             mem_rdata;

  fb_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .WFIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .fifo_flush(fifo_flush), .wfifo_level(wfifo_level),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (DW'(a) * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // Framebuffer RAM seen by the DUT
  logic [DW-1:0] ram [0:32767];
  bit            ram_wr [0:32767];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]    <= mem_wdata;
        ram_wr[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
      end
    end
  end

  // Reference model
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           q[$];
  int            starve;
  logic          e_en, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  bit            pend_w;
  logic [AW-1:0] pend_a;
  logic [DW-1:0] pend_d;
  bit            v1, v2;
  logic [DW-1:0] d1, d2;
  logic [DW-1:0] rmem [0:32767];
  bit            rmem_wr [0:32767];

  int pass_cnt = 0;
  int chk_cnt  = 0;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return rmem_wr[a] ? rmem[a] : init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic model_clear();
    q.delete();
    starve  = 0;
    e_en    = 1'b0;
    e_we    = 1'b0;
    e_addr  = '0;
    e_wdata = '0;
    pend_w  = 1'b0;
    v1      = 1'b0;
    v2      = 1'b0;
    d1      = '0;
    d2      = '0;
  endtask

  task automatic cycle(input bit rq, input logic [AW-1:0] ra, input bit wv,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd, input bit fl);
    bit  force_w, gnt_e, wr_e, rdy_e;
    int  sz;
    wr_t h;
    @(posedge clk);
    #1;
    rd_req     = rq;
    rd_addr    = ra;
    wr_valid   = wv;
    wr_addr    = wa;
    wr_data    = wd;
    fifo_flush = fl;
    #4;
    sz      = q.size();
    force_w = GUARD && (starve == SMAX) && (sz != 0) && !fl;
    gnt_e   = rq && !force_w;
    wr_e    = !gnt_e && (sz != 0) && !fl;
    rdy_e   = (sz < DEPTH) && !fl;

    chk("wfifo_level", 32'(wfifo_level), 32'(sz));
    chk("wr_ready", 32'(wr_ready), 32'(rdy_e));
    chk("rd_gnt", 32'(rd_gnt), 32'(gnt_e));
    chk("mem_en", 32'(mem_en), 32'(e_en));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    chk("rd_valid", 32'(rd_valid), 32'(v2));
    if (v2) chk("rd_data", 32'(rd_data), 32'(d2));

    // A write slot lands in the RAM one cycle after it is issued.
    if (pend_w) begin
      rmem[pend_a]    = pend_d;
      rmem_wr[pend_a] = 1'b1;
      pend_w          = 1'b0;
    end

    v2 = v1;
    d2 = d1;
    v1 = gnt_e;
    d1 = gnt_e ? ref_rd(ra) : '0;

    if (gnt_e) begin
      e_en   = 1'b1;
      e_we   = 1'b0;
      e_addr = ra;
    end else if (wr_e) begin
      h       = q.pop_front();
      e_en    = 1'b1;
      e_we    = 1'b1;
      e_addr  = h.a;
      e_wdata = h.d;
      pend_w  = 1'b1;
      pend_a  = h.a;
      pend_d  = h.d;
    end else begin
      e_en = 1'b0;
      e_we = 1'b0;
    end

    if (wv && rdy_e) q.push_back('{wa, wd});
    if (fl) q.delete();

    if (wr_e || fl || sz == 0) starve = 0;
    else starve++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n      = 1'b0;
    rd_req     = 1'b0;
    wr_valid   = 1'b0;
    fifo_flush = 1'b0;
    #1;
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_level", 32'(wfifo_level), 32'd0);
    model_clear();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    int p_rd;
    rst_n      = 1'b0;
    rd_req     = 1'b0;
    rd_addr    = '0;
    wr_valid   = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    fifo_flush = 1'b0;
    model_clear();

    do_reset();
    idle(3);

    // Back-to-back reads: latency and data
    for (int i = 0; i < 4; i++) cycle(1'b1, AW'(16'h100 + i), 1'b0, '0, '0, 1'b0);
    idle(4);

    // Write drain with no reads
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, AW'(16'h20 + i), DW'(16'hA000 + i), 1'b0);
    idle(6);

    // Read back what was written
    for (int i = 0; i < 4; i++) cycle(1'b1, AW'(16'h20 + i), 1'b0, '0, '0, 1'b0);
    idle(3);

    // Contention: continuous reads with a full FIFO, then drain
    for (int i = 0; i < 30; i++)
      cycle(1'b1, AW'(16'h100 + i), (i < 8), AW'(16'h40 + i), DW'(16'hB000 + i), 1'b0);
    idle(8);

    // Flush with a concurrent push
    for (int i = 0; i < 3; i++) cycle(1'b1, AW'(i), 1'b1, AW'(16'h60 + i), DW'(16'hC000 + i), 1'b0);
    cycle(1'b1, AW'(3), 1'b1, AW'(16'h63), DW'(16'hC003), 1'b1);
    idle(5);

    // Reset mid-burst with entries queued
    for (int i = 0; i < 3; i++) cycle(1'b1, AW'(i), 1'b1, AW'(16'h70 + i), DW'(16'hD000 + i), 1'b0);
    do_reset();
    idle(4);

    // Randomized traffic with read-pressure phases
    p_rd = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) begin
        case ($urandom_range(0, 3))
          0:       p_rd = 10;
          1:       p_rd = 50;
          2:       p_rd = 90;
          default: p_rd = 100;
        endcase
      end
      cycle($urandom_range(0, 99) < p_rd, AW'($urandom_range(0, 31)),
            $urandom_range(0, 99) < 60, AW'($urandom_range(0, 31)),
            DW'($urandom), $urandom_range(0, 99) < 2);
    end
    idle(10);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
